// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared types for the lc3b forwarding / load-use hazard tracker.
// The tracked-entry record describes one in-flight writer between EX and WB.
package fwd_hazard_tracker_pkg;

  localparam int LC3B_REG_W = 3;

  typedef logic [LC3B_REG_W-1:0] lc3b_reg;

  typedef struct packed {
    logic    valid;
    logic    regwrite;
    logic    is_load;
    lc3b_reg dest;
  } fwd_entry_t;

  localparam fwd_entry_t FWD_BUBBLE = '0;

  function automatic fwd_entry_t make_entry(input logic regwrite, input logic is_load,
                                            input lc3b_reg dest);
    fwd_entry_t e;
    e.valid    = 1'b1;
    e.regwrite = regwrite;
    e.is_load  = is_load;
    e.dest     = dest;
    return e;
  endfunction

endpackage

// File: rtl/fwd_hazard_tracker_src_select.sv
// Per-source bypass select: picks the youngest tracked writer of one source register
// and flags a load in EX that cannot forward yet.
module fwd_src_select
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int NUM_STAGES    = 3,
  parameter int REG_W         = 3,
  parameter int ZERO_REG_HARD = 0,
  parameter int SEL_W         = 2
) (
  input  logic                         id_valid,
  input  logic                         src_used,
  input  logic [REG_W-1:0]             src_reg,
  input  fwd_entry_t [NUM_STAGES-1:0]  stages,
  output logic [SEL_W-1:0]             sel,
  output logic                         load_hit
);

  logic [NUM_STAGES-1:0] match_vec;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign match_vec[gi] = id_valid & src_used & stages[gi].valid & stages[gi].regwrite
                           & (stages[gi].dest == src_reg)
                           & !((ZERO_REG_HARD != 0) && (stages[gi].dest == '0));
    end
  endgenerate

  always_comb begin
    sel      = '0;
    load_hit = match_vec[0] & stages[0].is_load;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (match_vec[k]) sel = SEL_W'(k + 1);
    end
    if (load_hit) sel = '0;
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding + load-use hazard unit; tracks in-flight writers EX..WB internally.
// Optional FWD_HAZARD_PERF_EN adds saturating stall / forward event counters.
module fwd_hazard_tracker
  import fwd_hazard_tracker_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int NUM_STAGES    = 3,
  parameter int REG_W         = 3,
  parameter int NREGS         = 8,
  parameter int ZERO_REG_HARD = 0,
  localparam int SEL_W        = $clog2(NUM_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [NUM_SRC*REG_W-1:0] id_src_reg,
  input  logic                     id_regwrite,
  input  logic [REG_W-1:0]         id_destreg,
  input  logic                     id_is_load,
  input  logic                     advance,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall_id,
  output logic [NREGS-1:0]         busy_mask
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);

  fwd_entry_t [NUM_STAGES-1:0] stage_q, stage_d;
  logic [NUM_SRC-1:0]          load_hit;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_select #(
        .NUM_STAGES   (NUM_STAGES),
        .REG_W        (REG_W),
        .ZERO_REG_HARD(ZERO_REG_HARD),
        .SEL_W        (SEL_W)
      ) u_sel (
        .id_valid(id_valid),
        .src_used(id_src_used[gi]),
        .src_reg (id_src_reg[gi*REG_W +: REG_W]),
        .stages  (stage_q),
        .sel     (fwd_sel[gi*SEL_W +: SEL_W]),
        .load_hit(load_hit[gi])
      );
    end
  endgenerate

  // A flushed instruction dies anyway, so it never needs to wait on a load.
  assign stall_id = (|load_hit) & !flush;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q[k].valid && stage_q[k].regwrite) busy_mask[stage_q[k].dest] = 1'b1;
    end
  end

  always_comb begin
    stage_d = stage_q;
    if (advance) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) stage_d[k] = stage_q[k-1];
      stage_d[0] = (id_valid && !stall_id && !flush)
                 ? make_entry(id_regwrite, id_is_load, lc3b_reg'(id_destreg))
                 : FWD_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_fwd_cnt_q, perf_fwd_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_fwd_cnt_d   = perf_fwd_cnt_q;
    if (stall_id && !(&perf_stall_cnt_q)) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (advance && (|fwd_sel) && !(&perf_fwd_cnt_q)) perf_fwd_cnt_d = perf_fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt_q <= '0;
      perf_fwd_cnt_q   <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_fwd_cnt   = perf_fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Self-checking bench for fwd_hazard_tracker: directed scenarios plus random stimulus
// compared against a simple in-order pipeline model.
module tb_fwd_hazard_tracker;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [1:0] id_src_used;
  logic [5:0] id_src_reg;
  logic       id_regwrite;
  logic [2:0] id_destreg;
  logic       id_is_load;
  logic       advance;
  logic       flush;
  logic [3:0] fwd_sel;
  logic       stall_id;
  logic [7:0] busy_mask;
  logic [3:0] z_sel;
  logic       z_stall;
  logic [7:0] z_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: writers in flight, index 1 = EX .. 3 = WB
  int mv[4], mw[4], ml[4], md[4];
  logic [3:0] exp_sel;
  logic       exp_stall;
  logic [7:0] exp_busy;

  fwd_hazard_tracker dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_used(id_src_used),
    .id_src_reg(id_src_reg), .id_regwrite(id_regwrite), .id_destreg(id_destreg),
    .id_is_load(id_is_load), .advance(advance), .flush(flush),
    .fwd_sel(fwd_sel), .stall_id(stall_id), .busy_mask(busy_mask)
  );

  fwd_hazard_tracker #(.ZERO_REG_HARD(1)) dut_z (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_used(id_src_used),
    .id_src_reg(id_src_reg), .id_regwrite(id_regwrite), .id_destreg(id_destreg),
    .id_is_load(id_is_load), .advance(advance), .flush(flush),
    .fwd_sel(z_sel), .stall_id(z_stall), .busy_mask(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void model_clear();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0; mw[k] = 0; ml[k] = 0; md[k] = 0;
    end
  endfunction

  function void model_eval();
    int src;
    int hit;
    exp_sel = '0; exp_stall = 1'b0; exp_busy = '0;
    for (int k = 1; k <= 3; k++) if (mv[k] != 0 && mw[k] != 0) exp_busy[md[k]] = 1'b1;
    if (id_valid) begin
      for (int i = 0; i < 2; i++) begin
        if (id_src_used[i]) begin
          src = int'(id_src_reg[i*3 +: 3]);
          hit = 0;
          for (int k = 1; k <= 3; k++)
            if (hit == 0 && mv[k] != 0 && mw[k] != 0 && md[k] == src) hit = k;
          if (hit == 1 && ml[1] != 0) exp_stall = 1'b1;
          else exp_sel[i*2 +: 2] = 2'(hit);
        end
      end
    end
    if (flush) exp_stall = 1'b0;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset) model_clear();
    else if (advance) begin
      for (int k = 3; k >= 2; k--) begin
        mv[k] = mv[k-1]; mw[k] = mw[k-1]; ml[k] = ml[k-1]; md[k] = md[k-1];
      end
      if (id_valid && !exp_stall && !flush) begin
        mv[1] = 1; mw[1] = int'(id_regwrite); ml[1] = int'(id_is_load); md[1] = int'(id_destreg);
      end else begin
        mv[1] = 0; mw[1] = 0; ml[1] = 0; md[1] = 0;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] used, input int s0, input int s1,
                        input logic wr, input int dst, input logic ld, input logic adv,
                        input logic fl);
    id_valid = v; id_src_used = used;
    id_src_reg = {3'(s1), 3'(s0)};
    id_regwrite = wr; id_destreg = 3'(dst); id_is_load = ld;
    advance = adv; flush = fl;
  endtask

  task automatic flush_pipe();
    set_in(0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    set_in(1, 2'b11, 1, 2, 1, 1, 1, 1, 0);
    #1;
    n_checks++; if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0000", fwd_sel); end
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_id); end
    n_checks++; if (busy_mask !== 8'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_mask); end
    @(posedge clk); #1;
    n_checks++; if (busy_mask !== 8'b0) begin n_fail++; $display("FAIL reset_hold_busy got %b exp 0", busy_mask); end
    #2 reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 1, 0, 1, 0); tick();
    set_in(1, 2'b11, 1, 1, 1, 2, 0, 1, 0); #1;
    n_checks++; if (fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL b2b_sel got %b exp 0101", fwd_sel); end
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b exp 0", stall_id); end
    n_checks++; if (busy_mask !== 8'b0000_0010) begin n_fail++; $display("FAIL b2b_busy got %b exp 00000010", busy_mask); end
    tick();
    $display("test_back_to_back sel=%b stall=%b", fwd_sel, stall_id);
  endtask

  task automatic test_load_use();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 3, 1, 1, 0); tick();
    set_in(1, 2'b11, 3, 0, 1, 4, 0, 1, 0); #1;
    n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall1 got %b exp 1", stall_id); end
    n_checks++; if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL lu_sel1 got %b exp 0000", fwd_sel); end
    tick();
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_stall2 got %b exp 0", stall_id); end
    n_checks++; if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL lu_sel2 got %b exp 0010", fwd_sel); end
    n_checks++; if (busy_mask !== 8'b0000_1000) begin n_fail++; $display("FAIL lu_bubble_busy got %b exp 00001000", busy_mask); end
    tick();
    $display("test_load_use sel=%b stall=%b", fwd_sel, stall_id);
  endtask

  task automatic test_youngest();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 5, 0, 1, 0); tick();
    set_in(1, 2'b00, 0, 0, 1, 6, 0, 1, 0); tick();
    set_in(1, 2'b00, 0, 0, 1, 5, 0, 1, 0); tick();
    set_in(1, 2'b11, 5, 6, 0, 0, 0, 1, 0); #1;
    n_checks++; if (fwd_sel !== 4'b1001) begin n_fail++; $display("FAIL young_sel got %b exp 1001", fwd_sel); end
    n_checks++; if (busy_mask !== 8'b0110_0000) begin n_fail++; $display("FAIL young_busy got %b exp 01100000", busy_mask); end
    tick();
    $display("test_youngest busy=%b", busy_mask);
  endtask

  task automatic test_stall_freeze();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 2, 1, 1, 0); tick();
    set_in(1, 2'b01, 2, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL frz_stall c%0d got %b exp 1", c, stall_id); end
      n_checks++; if (busy_mask !== 8'b0000_0100) begin n_fail++; $display("FAIL frz_busy c%0d got %b exp 00000100", c, busy_mask); end
      tick();
    end
    advance = 1'b1; tick();
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL frz_release got %b exp 0", stall_id); end
    n_checks++; if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL frz_sel got %b exp 0010", fwd_sel); end
    tick();
    $display("test_stall_freeze done");
  endtask

  task automatic test_flush();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 3, 1, 1, 0); tick();
    set_in(1, 2'b01, 3, 0, 1, 7, 0, 1, 1); #1;
    n_checks++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall_id); end
    tick();
    set_in(1, 2'b01, 3, 0, 0, 0, 0, 1, 0); #1;
    n_checks++; if (busy_mask !== 8'b0000_1000) begin n_fail++; $display("FAIL flush_busy got %b exp 00001000", busy_mask); end
    n_checks++; if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL flush_sel got %b exp 0010", fwd_sel); end
    tick();
    $display("test_flush done");
  endtask

  task automatic test_zero_reg();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 0, 0, 1, 0); tick();
    set_in(1, 2'b01, 0, 0, 0, 0, 0, 1, 0); #1;
    n_checks++; if (z_sel !== 4'b0000) begin n_fail++; $display("FAIL zero_hard_sel got %b exp 0000", z_sel); end
    n_checks++; if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL zero_soft_sel got %b exp 0001", fwd_sel); end
    tick();
    $display("test_zero_reg hard=%b soft=%b", z_sel, fwd_sel);
  endtask

  task automatic test_reset_mid();
    flush_pipe();
    set_in(1, 2'b00, 0, 0, 1, 1, 0, 1, 0); tick();
    set_in(1, 2'b00, 0, 0, 1, 2, 0, 1, 0); tick();
    set_in(1, 2'b11, 1, 2, 0, 0, 0, 1, 0); #1;
    n_checks++; if (fwd_sel !== 4'b0110) begin n_fail++; $display("FAIL rmid_pre_sel got %b exp 0110", fwd_sel); end
    #2 reset = 1'b1;
    model_clear();
    #1;
    n_checks++; if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL rmid_sel got %b exp 0000", fwd_sel); end
    n_checks++; if (busy_mask !== 8'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy_mask); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (fwd_sel !== 4'b0) begin n_fail++; $display("FAIL rmid_post_sel got %b exp 0000", fwd_sel); end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 99) < 85), 2'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 80),
             ($urandom_range(0, 99) < 8));
      #1;
      model_eval();
      n_checks++; if (fwd_sel !== exp_sel) begin n_fail++; errs++; $display("FAIL rnd_sel n%0d got %b exp %b", n, fwd_sel, exp_sel); end
      n_checks++; if (stall_id !== exp_stall) begin n_fail++; errs++; $display("FAIL rnd_stall n%0d got %b exp %b", n, stall_id, exp_stall); end
      n_checks++; if (busy_mask !== exp_busy) begin n_fail++; errs++; $display("FAIL rnd_busy n%0d got %b exp %b", n, busy_mask, exp_busy); end
      tick();
    end
    $display("test_random 400 cycles, %0d errors", errs);
  endtask

  initial begin
    set_in(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_stall_freeze();
    test_flush();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
